// File: rtl/alu_pkg.sv
// Shared opcode/funct encodings, flag bit positions and shifter modes for the execute-stage ALU.
package alu_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned FLAG_W  = 3;

  // Flag bit positions within {zero, negative, overflow}
  localparam int unsigned ZERO = 2;
  localparam int unsigned NEG  = 1;
  localparam int unsigned OVF  = 0;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  typedef enum logic [1:0] {
    SH_LL = 2'd0,
    SH_RL = 2'd1,
    SH_RA = 2'd2
  } shift_mode_e;

  // Register code 0 reads regA, every other code reads regB
  function automatic logic [DATA_W-1:0] sel_operand(input logic [4:0]        code,
                                                    input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b);
    return (code == 5'd0) ? a : b;
  endfunction

endpackage

// File: rtl/alu_if.sv
// Instruction/operand/result bundle between register-read, ALU and writeback.
interface alu_if;
  import alu_pkg::*;

  logic [DATA_W-1:0] instruction;
  logic [DATA_W-1:0] regA;
  logic [DATA_W-1:0] regB;
  logic [DATA_W-1:0] result;
  logic [FLAG_W-1:0] flags;

  modport master (output instruction, regA, regB, input result, flags);
  modport slave  (input instruction, regA, regB, output result, flags);
endinterface

// File: rtl/alu_shifter.sv
// Five-stage logarithmic barrel shifter: logical left, logical right, arithmetic right.
module alu_shifter
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0]  data_i,
  input  logic [SHAMT_W-1:0] amt_i,
  input  shift_mode_e        mode_i,
  output logic [DATA_W-1:0]  data_o
);

  logic [DATA_W-1:0] stg [0:SHAMT_W];
  logic              left;
  logic              fill;

  assign left   = (mode_i == SH_LL);
  assign fill   = (mode_i == SH_RA) & data_i[DATA_W-1];
  assign stg[0] = data_i;

  // Stage g shifts by 2**g when amount bit g is set
  for (genvar g = 0; g < SHAMT_W; g++) begin : g_stage
    localparam int unsigned SH = 1 << g;
    assign stg[g+1] = !amt_i[g] ? stg[g] :
                      left      ? {stg[g][DATA_W-1-SH:0], {SH{1'b0}}} :
                                  {{SH{fill}}, stg[g][DATA_W-1:SH]};
  end

  assign data_o = stg[SHAMT_W];

endmodule

// File: rtl/alu.sv
// MIPS-subset execute-stage ALU: combinational decode/compute, result and flags registered.
module alu
  import alu_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  alu_if.slave  bus
);

  logic [5:0]         op;
  logic [5:0]         funct;
  logic [4:0]         rs;
  logic [4:0]         rt;
  logic [4:0]         shamt;
  logic [15:0]        imm;
  logic [DATA_W-1:0]  s_val;
  logic [DATA_W-1:0]  t_val;
  logic [DATA_W-1:0]  se;
  logic [DATA_W-1:0]  ze;

  assign op    = bus.instruction[31:26];
  assign rs    = bus.instruction[25:21];
  assign rt    = bus.instruction[20:16];
  assign shamt = bus.instruction[10:6];
  assign funct = bus.instruction[5:0];
  assign imm   = bus.instruction[15:0];

  assign s_val = sel_operand(rs, bus.regA, bus.regB);
  assign t_val = sel_operand(rt, bus.regA, bus.regB);
  assign se    = {{16{imm[15]}}, imm};
  assign ze    = {16'h0000, imm};

  // Shared shifter: funct[2] picks the variable amount, funct[1:0] the direction
  logic [SHAMT_W-1:0] sh_amt;
  shift_mode_e        sh_mode;
  logic [DATA_W-1:0]  sh_out;

  assign sh_amt = funct[2] ? s_val[SHAMT_W-1:0] : shamt;

  always_comb begin
    sh_mode = SH_LL;
    case (funct[1:0])
      2'b10:   sh_mode = SH_RL;
      2'b11:   sh_mode = SH_RA;
      default: sh_mode = SH_LL;
    endcase
  end

  alu_shifter u_shifter (
    .data_i (t_val),
    .amt_i  (sh_amt),
    .mode_i (sh_mode),
    .data_o (sh_out)
  );

  logic [DATA_W-1:0] add_st;
  logic [DATA_W-1:0] sub_st;
  logic [DATA_W-1:0] add_si;
  logic              add_ovf;
  logic              sub_ovf;
  logic              addi_ovf;
  logic              lt_s;
  logic              lt_u;
  logic              lti_s;
  logic              lti_u;

  assign add_st = s_val + t_val;
  assign sub_st = s_val - t_val;
  assign add_si = s_val + se;

  // Signed overflow: result sign departs from S when operand signs allow it
  assign add_ovf  = (s_val[DATA_W-1] == t_val[DATA_W-1]) && (add_st[DATA_W-1] != s_val[DATA_W-1]);
  assign sub_ovf  = (s_val[DATA_W-1] != t_val[DATA_W-1]) && (sub_st[DATA_W-1] != s_val[DATA_W-1]);
  assign addi_ovf = (s_val[DATA_W-1] == se[DATA_W-1])    && (add_si[DATA_W-1] != s_val[DATA_W-1]);

  assign lt_s  = $signed(s_val) < $signed(t_val);
  assign lt_u  = s_val < t_val;
  assign lti_s = $signed(s_val) < $signed(se);
  assign lti_u = s_val < se;

  logic [DATA_W-1:0] result_d, result_q;
  logic [FLAG_W-1:0] flags_d,  flags_q;

  always_comb begin
    result_d = '0;
    flags_d  = '0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  begin result_d = add_st; flags_d[OVF] = add_ovf; end
          FN_ADDU: result_d = add_st;
          FN_SUB:  begin result_d = sub_st; flags_d[OVF] = sub_ovf; end
          FN_SUBU: result_d = sub_st;
          FN_AND:  result_d = s_val & t_val;
          FN_OR:   result_d = s_val | t_val;
          FN_XOR:  result_d = s_val ^ t_val;
          FN_NOR:  result_d = ~(s_val | t_val);
          FN_SLT:  begin result_d = DATA_W'(lt_s); flags_d[NEG] = lt_s; end
          FN_SLTU: begin result_d = DATA_W'(lt_u); flags_d[NEG] = lt_u; end
          FN_SLL, FN_SRL, FN_SRA,
          FN_SLLV, FN_SRLV, FN_SRAV: result_d = sh_out;
          default: ;
        endcase
      end
      OP_ADDI:       begin result_d = add_si; flags_d[OVF] = addi_ovf; end
      OP_ADDIU:      result_d = add_si;
      OP_SLTI:       begin result_d = DATA_W'(lti_s); flags_d[NEG] = lti_s; end
      OP_SLTIU:      begin result_d = DATA_W'(lti_u); flags_d[NEG] = lti_u; end
      OP_ANDI:       result_d = s_val & ze;
      OP_ORI:        result_d = s_val | ze;
      OP_XORI:       result_d = s_val ^ ze;
      OP_BEQ, OP_BNE: begin result_d = sub_st; flags_d[ZERO] = (sub_st == '0); end
      OP_LW, OP_SW:  result_d = add_si;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  assign bus.result = result_q;
  assign bus.flags  = flags_q;

endmodule

// File: tb/tb_alu.sv
// Randomized bench for alu with an arithmetic reference model and hand-computed anchor vectors.
module tb_alu;

  logic clk = 1'b0;
  logic rst;
  int   n_vec  = 0;
  int   n_miss = 0;

  alu_if bus ();

  alu u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam longint MAXS = 64'sd2147483647;
  localparam longint MINS = -64'sd2147483648;

  function automatic bit ovf32(input longint v);
    return (v > MAXS) || (v < MINS);
  endfunction

  // Reference: returns {result, zero, negative, overflow}
  function automatic logic [34:0] model(input logic [31:0] ins, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] s, t, se, ze, r;
    logic [2:0]  f;
    longint      ls, lt, lse, wide;
    int          n, nv;
    s   = (ins[25:21] == 5'd0) ? a : b;
    t   = (ins[20:16] == 5'd0) ? a : b;
    se  = {{16{ins[15]}}, ins[15:0]};
    ze  = {16'h0000, ins[15:0]};
    ls  = longint'($signed(s));
    lt  = longint'($signed(t));
    lse = longint'($signed(se));
    n   = int'(ins[10:6]);
    nv  = int'(s[4:0]);
    r   = 32'd0;
    f   = 3'b000;
    wide = 64'sd0;
    if (ins[31:26] == 6'h00) begin
      case (ins[5:0])
        6'h20: begin wide = ls + lt; r = wide[31:0]; f[0] = ovf32(wide); end
        6'h21: begin wide = ls + lt; r = wide[31:0]; end
        6'h22: begin wide = ls - lt; r = wide[31:0]; f[0] = ovf32(wide); end
        6'h23: begin wide = ls - lt; r = wide[31:0]; end
        6'h24: r = s & t;
        6'h25: r = s | t;
        6'h26: r = s ^ t;
        6'h27: r = ~(s | t);
        6'h2A: begin r = (ls < lt) ? 32'd1 : 32'd0; f[1] = (ls < lt); end
        6'h2B: begin r = (s < t) ? 32'd1 : 32'd0; f[1] = (s < t); end
        6'h00: r = t << n;
        6'h02: r = t >> n;
        6'h03: r = $signed(t) >>> n;
        6'h04: r = t << nv;
        6'h06: r = t >> nv;
        6'h07: r = $signed(t) >>> nv;
        default: ;
      endcase
    end else begin
      case (ins[31:26])
        6'h08: begin wide = ls + lse; r = wide[31:0]; f[0] = ovf32(wide); end
        6'h09, 6'h23, 6'h2B: begin wide = ls + lse; r = wide[31:0]; end
        6'h0A: begin r = (ls < lse) ? 32'd1 : 32'd0; f[1] = (ls < lse); end
        6'h0B: begin r = (s < se) ? 32'd1 : 32'd0; f[1] = (s < se); end
        6'h0C: r = s & ze;
        6'h0D: r = s | ze;
        6'h0E: r = s ^ ze;
        6'h04, 6'h05: begin wide = ls - lt; r = wide[31:0]; f[2] = (r == 32'd0); end
        default: ;
      endcase
    end
    return {r, f};
  endfunction

  // Expected output one edge after inputs are sampled
  logic [31:0] exp_r;
  logic [2:0]  exp_f;
  logic        exp_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) {exp_r, exp_f} <= 35'd0;
    else     {exp_r, exp_f} <= model(bus.instruction, bus.regA, bus.regB);
    exp_valid <= 1'b1;
  end

  always @(negedge clk) begin
    if (exp_valid) begin
      n_vec++;
      if (bus.result !== exp_r || bus.flags !== exp_f) begin
        n_miss++;
        if (n_miss < 20)
          $display("FAIL cycle t=%0t ins=%h got result=%h flags=%b want result=%h flags=%b",
                   $time, bus.instruction, bus.result, bus.flags, exp_r, exp_f);
      end
    end
  end

  task automatic dir(input string name, input logic [31:0] ins, input logic [31:0] a,
                     input logic [31:0] b, input logic r, input logic [31:0] er,
                     input logic [2:0] ef);
    logic [34:0] m;
    @(negedge clk);
    bus.instruction = ins;
    bus.regA        = a;
    bus.regB        = b;
    rst             = r;
    if (!r) begin
      m = model(ins, a, b);
      n_vec++;
      if (m !== {er, ef}) begin
        n_miss++;
        $display("FAIL model %s got %h/%b want %h/%b", name, m[34:3], m[2:0], er, ef);
      end
    end
    @(negedge clk);
    n_vec++;
    if (bus.result !== er || bus.flags !== ef) begin
      n_miss++;
      $display("FAIL %s got result=%h flags=%b want result=%h flags=%b",
               name, bus.result, bus.flags, er, ef);
    end
  endtask

  logic [5:0] fn_tab [16] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                              6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07};
  logic [5:0] op_tab [11] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E,
                              6'h04, 6'h05, 6'h23, 6'h2B};

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return 32'h7FFFFFFF - 32'($urandom_range(0, 8));
      1:       return 32'h80000000 + 32'($urandom_range(0, 8));
      2:       return 32'($urandom_range(0, 40));
      3:       return 32'hFFFFFFFF - 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] ins, a, b;
    rst             = 1'b1;
    bus.instruction = 32'h0;
    bus.regA        = 32'h0;
    bus.regB        = 32'h0;
    dir("reset_state", 32'h00014020, 32'd4, 32'd5, 1'b1, 32'h0, 3'b000);

    dir("add",          32'h00014020, 32'd4,        32'd5,        1'b0, 32'd9,        3'b000);
    dir("add_to_zero",  32'h00014020, -32'sd10,     32'd10,       1'b0, 32'd0,        3'b000);
    dir("add_ovf_pos",  32'h00014020, 32'h7FFFFFF8, 32'h7FFFFFF9, 1'b0, 32'hFFFFFFF1, 3'b001);
    dir("add_ovf_neg",  32'h00014020, 32'h80000008, 32'h80000007, 1'b0, 32'h0000000F, 3'b001);
    dir("addi",         32'h2020FF9C, 32'd0,        32'd19,       1'b0, 32'hFFFFFFAF, 3'b000);
    dir("addi_ovf",     32'h2020FF9C, 32'd0,        32'h80000008, 1'b0, 32'h7FFFFFA4, 3'b001);
    dir("addu_no_ovf",  32'h00014021, 32'h7FFFFFF8, 32'h7FFFFFF9, 1'b0, 32'hFFFFFFF1, 3'b000);
    dir("addiu",        32'h24000064, 32'd200,      32'd7,        1'b0, 32'd300,      3'b000);
    dir("sub",          32'h00014022, 32'd99,       32'd25,       1'b0, 32'd74,       3'b000);
    dir("sub_swapped",  32'h00204022, -32'sd65,     -32'sd39,     1'b0, 32'd26,       3'b000);
    dir("sub_ovf",      32'h00014022, 32'h80000008, 32'h7FFFFFF9, 1'b0, 32'h0000000F, 3'b001);
    dir("subu",         32'h00014023, 32'd50,       32'd120,      1'b0, 32'hFFFFFFBA, 3'b000);
    dir("pre_reset",    32'h00014020, 32'd1,        32'd2,        1'b0, 32'd3,        3'b000);
    dir("mid_reset",    32'h00014020, 32'd1,        32'd2,        1'b1, 32'd0,        3'b000);
    dir("beq_equal",    32'h10010000, 32'd7,        32'd7,        1'b0, 32'd0,        3'b100);
    dir("slt",          32'h0001402A, 32'hFFFFFFFF, 32'd1,        1'b0, 32'd1,        3'b010);
    dir("sltu",         32'h0001402B, 32'hFFFFFFFF, 32'd1,        1'b0, 32'd0,        3'b000);
    dir("sra",          32'h00004043, 32'h80000000, 32'd0,        1'b0, 32'hC0000000, 3'b000);
    dir("unsupported",  32'hFC000000, 32'd5,        32'd6,        1'b0, 32'd0,        3'b000);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      ins = $urandom;
      if ($urandom_range(0, 15) != 0) begin
        if ($urandom_range(0, 1) == 0) begin
          ins[31:26] = 6'h00;
          ins[5:0]   = fn_tab[$urandom_range(0, 15)];
        end else begin
          ins[31:26] = op_tab[$urandom_range(0, 10)];
        end
      end
      if ($urandom_range(0, 1) == 0) ins[25:21] = 5'd0;
      if ($urandom_range(0, 1) == 0) ins[20:16] = 5'd0;
      a = pick_val();
      b = ($urandom_range(0, 7) == 0) ? a : pick_val();
      bus.instruction = ins;
      bus.regA        = a;
      bus.regB        = b;
      rst             = ($urandom_range(0, 31) == 0);
    end

    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
